s5_mem_access: RTL and testbench

//  Stage-5 memory-access stage of the RISC-V pipeline; sits between the stage-4 register and s6_Forward.

---
 rtl/s5_mem_access_pkg.sv | 30 +++
 rtl/s5_mem_access_if.sv | 14 +
 rtl/s5_load_align.sv | 26 ++
 rtl/s5_mem_access.sv | 203 ++++++++++++++++++++
 tb/tb_s5_mem_access.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/s5_mem_access_pkg.sv
// Shared definitions for the stage-5 memory-access block: access-size codes,
// FSM state encoding and the alignment-fault check.
package s5_mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // A memory op is dropped when it is both load and store, or when a
  // halfword/word access is not naturally aligned.
  function automatic logic access_fault(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic f;
    f = rd & wr;
    if ((f3 == F3_H || f3 == F3_HU) && off[0]) f = 1'b1;
    if (f3 == F3_W && off != 2'b00)            f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/s5_mem_access_if.sv
// Data-memory req/ack bus. The stage is the master; the memory answers with
// ack and rdata in the same cycle.
interface s5_mem_access_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, wdata, be, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/s5_load_align.sv
// Load formatter: shifts the addressed lane down to bit 0, then sign- or
// zero-extends according to the access size.
module s5_load_align
  import s5_mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  // lane select and extension
  always_comb begin
    lane = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    data = {{24{lane[7]}},  lane[7:0]};
      F3_H:    data = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   data = {24'd0, lane[7:0]};
      F3_HU:   data = {16'd0, lane[15:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/s5_mem_access.sv
// Stage-5 memory access: passes ALU results through, runs loads/stores on
// the req/ack data bus, stalls upstream while a transaction is in flight and
// delivers the AluOut/Rd/regesterW triple to stage 6.
module s5_mem_access
  import s5_mem_access_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] AluOut,
  input  logic [XLEN-1:0] Rs2,
  input  logic [4:0]      Rd,
  input  logic            regesterW,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] AluOuto,
  output logic [4:0]      Rdo,
  output logic            regesterWo,
  output logic            misaligned,
  output logic            stall_req,
  s5_mem_access_if.master dmem
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [4:0]        rd_q, rd_d;
  logic              regw_q, regw_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [XLEN-1:0]   aluo_q, aluo_d;
  logic [4:0]        rdo_q, rdo_d;
  logic              regwo_q, regwo_d;
  logic              mis_q, mis_d;

  logic              memop, fault;
  logic [31:0]       st_wdata;
  logic [3:0]        st_be;
  logic [31:0]       ld_data;
  logic [XLEN-1:0]   result;

  assign memop = memRead | memWrite;
  assign fault = access_fault(memRead, memWrite, funct3, AluOut[1:0]);

  // store lane replication and byte enables from the incoming request
  always_comb begin
    st_wdata = Rs2;
    st_be    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{Rs2[7:0]}};
        st_be    = 4'b0001 << AluOut[1:0];
      end
      2'b01: begin
        st_wdata = {2{Rs2[15:0]}};
        st_be    = AluOut[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  s5_load_align u_align (
    .rdata  (dmem.rdata),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  // stores report their address; loads report the formatted read data
  assign result = we_q ? addr_q : ld_data;

  // next-state and next-output logic of the transaction FSM
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rd_d      = rd_q;
    regw_d    = regw_q;
    f3_d      = f3_q;
    res_d     = res_q;
    aluo_d    = aluo_q;
    rdo_d     = rdo_q;
    regwo_d   = regwo_q;
    mis_d     = 1'b0;
    stall_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stall) begin
          if (!memop) begin
            aluo_d  = AluOut;
            rdo_d   = Rd;
            regwo_d = regesterW;
          end else if (fault) begin
            aluo_d  = '0;
            rdo_d   = '0;
            regwo_d = 1'b0;
            mis_d   = 1'b1;
          end else begin
            stall_req = 1'b1;
            req_d     = 1'b1;
            we_d      = memWrite;
            addr_d    = AluOut;
            wdata_d   = st_wdata;
            be_d      = memWrite ? st_be : 4'b0000;
            rd_d      = Rd;
            regw_d    = regesterW;
            f3_d      = funct3;
            aluo_d    = '0;
            rdo_d     = '0;
            regwo_d   = 1'b0;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall_req = !(dmem.ack && !stall);
        if (dmem.ack) begin
          req_d = 1'b0;
          if (!stall) begin
            aluo_d  = result;
            rdo_d   = rd_q;
            regwo_d = regw_q;
            state_d = ST_IDLE;
          end else begin
            res_d   = result;
            state_d = ST_HOLD;
          end
        end else if (!stall) begin
          aluo_d  = '0;
          rdo_d   = '0;
          regwo_d = 1'b0;
        end
      end
      ST_HOLD: begin
        stall_req = stall;
        if (!stall) begin
          aluo_d  = res_q;
          rdo_d   = rd_q;
          regwo_d = regw_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers; reset drops any outstanding request at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      regw_q  <= 1'b0;
      f3_q    <= '0;
      res_q   <= '0;
      aluo_q  <= '0;
      rdo_q   <= '0;
      regwo_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      regw_q  <= regw_d;
      f3_q    <= f3_d;
      res_q   <= res_d;
      aluo_q  <= aluo_d;
      rdo_q   <= rdo_d;
      regwo_q <= regwo_d;
      mis_q   <= mis_d;
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;

  assign AluOuto    = aluo_q;
  assign Rdo        = rdo_q;
  assign regesterWo = regwo_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_s5_mem_access.sv
// Directed bench for s5_mem_access: single-cycle vectors from a table, then
// hand-written load/store/hold/reset sequences against a scripted memory.
module tb_s5_mem_access;

  logic        clk, rst, stall;
  logic [31:0] AluOut, Rs2;
  logic [4:0]  Rd;
  logic        regesterW, memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] AluOuto;
  logic [4:0]  Rdo;
  logic        regesterWo, misaligned, stall_req;

  int checks = 0;
  int errors = 0;

  s5_mem_access_if #(.ADDR_W(32)) dmem ();

  s5_mem_access #(.XLEN(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .AluOut     (AluOut),
    .Rs2        (Rs2),
    .Rd         (Rd),
    .regesterW  (regesterW),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .AluOuto    (AluOuto),
    .Rdo        (Rdo),
    .regesterWo (regesterWo),
    .misaligned (misaligned),
    .stall_req  (stall_req),
    .dmem       (dmem.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        regw, mr, mw;
    logic [2:0]  f3;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
    logic        e_regw, e_mis;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic nop_inputs();
    AluOut = 0; Rs2 = 0; Rd = 0; regesterW = 0;
    memRead = 0; memWrite = 0; funct3 = 0;
  endtask

  initial begin
    int cnt;
    vecs[0] = '{32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 5'd5,  1'b1, 1'b0};
    vecs[1] = '{32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0, 1'b0, 3'b010, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0101, 5'd3,  1'b1, 1'b1, 1'b0, 3'b010, 32'h0,         5'd0,  1'b0, 1'b1};
    vecs[3] = '{32'h0000_0003, 5'd4,  1'b1, 1'b1, 1'b0, 3'b001, 32'h0,         5'd0,  1'b0, 1'b1};
    vecs[4] = '{32'h0000_0002, 5'd0,  1'b0, 1'b0, 1'b1, 3'b010, 32'h0,         5'd0,  1'b0, 1'b1};
    vecs[5] = '{32'h0000_0000, 5'd6,  1'b1, 1'b1, 1'b1, 3'b000, 32'h0,         5'd0,  1'b0, 1'b1};
    vecs[6] = '{32'h0000_CAFE, 5'd1,  1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_CAFE, 5'd1,  1'b1, 1'b0};

    rst = 1'b0; stall = 1'b0;
    nop_inputs();
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_aluo",  AluOuto, 32'h0);
    chk("rst_rdo",   32'(Rdo), 32'h0);
    chk("rst_regwo", 32'(regesterWo), 32'h0);
    chk("rst_mis",   32'(misaligned), 32'h0);
    chk("rst_sreq",  32'(stall_req), 32'h0);
    chk("rst_req",   32'(dmem.req), 32'h0);
    @(negedge clk) rst = 1'b1;

    // single-cycle pass-through and fault vectors
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      AluOut = vecs[i].alu; Rd = vecs[i].rd; regesterW = vecs[i].regw;
      memRead = vecs[i].mr; memWrite = vecs[i].mw; funct3 = vecs[i].f3;
      #1 chk($sformatf("v%0d_sreq", i), 32'(stall_req), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_aluo", i),  AluOuto, vecs[i].e_alu);
      chk($sformatf("v%0d_rdo", i),   32'(Rdo), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_regwo", i), 32'(regesterWo), 32'(vecs[i].e_regw));
      chk($sformatf("v%0d_mis", i),   32'(misaligned), 32'(vecs[i].e_mis));
      chk($sformatf("v%0d_req", i),   32'(dmem.req), 32'h0);
    end

    // global stall holds outputs and suppresses a new request
    @(negedge clk);
    stall = 1'b1; AluOut = 32'h9999; Rd = 5'd2; memRead = 1'b0;
    @(posedge clk); #1;
    chk("stall_hold_aluo", AluOuto, 32'h0000_CAFE);
    @(negedge clk);
    AluOut = 32'h40; memRead = 1'b1; funct3 = 3'b010;
    #1 chk("stall_ld_sreq", 32'(stall_req), 32'h0);
    @(posedge clk); #1;
    chk("stall_ld_noreq", 32'(dmem.req), 32'h0);
    chk("stall_hold_rdo", 32'(Rdo), 32'd1);
    @(negedge clk); stall = 1'b0; nop_inputs();

    // LB at 0x103, ack in the third BUSY cycle
    @(negedge clk);
    cnt = 0;
    AluOut = 32'h103; memRead = 1'b1; funct3 = 3'b000; Rd = 5'd7; regesterW = 1'b1;
    #1 if (stall_req) cnt++;
    @(posedge clk); #1;
    chk("lb_req",   32'(dmem.req), 32'h1);
    chk("lb_we",    32'(dmem.we), 32'h0);
    chk("lb_addr",  dmem.addr, 32'h100);
    chk("lb_regwo_bubble", 32'(regesterWo), 32'h0);
    @(negedge clk); nop_inputs();
    #1 if (stall_req) cnt++;
    @(negedge clk);
    #1 if (stall_req) cnt++;
    @(negedge clk);
    dmem.ack = 1'b1; dmem.rdata = 32'h80FF_FF00;
    #1 if (stall_req) cnt++;
    chk("lb_ack_sreq", 32'(stall_req), 32'h0);
    @(posedge clk); #1;
    chk("lb_aluo",  AluOuto, 32'hFFFF_FF80);
    chk("lb_rdo",   32'(Rdo), 32'd7);
    chk("lb_regwo", 32'(regesterWo), 32'h1);
    chk("lb_req_drop", 32'(dmem.req), 32'h0);
    chk("lb_stall_cycles", 32'(cnt), 32'd3);
    @(negedge clk); dmem.ack = 1'b0; dmem.rdata = 32'h0;

    // SH at 0x202, ack in the first BUSY cycle
    @(negedge clk);
    AluOut = 32'h202; Rs2 = 32'h0000_ABCD; memWrite = 1'b1; funct3 = 3'b001;
    Rd = 5'd0; regesterW = 1'b0;
    @(posedge clk); #1;
    chk("sh_req",   32'(dmem.req), 32'h1);
    chk("sh_we",    32'(dmem.we), 32'h1);
    chk("sh_be",    32'(dmem.be), 32'hC);
    chk("sh_wdata", dmem.wdata, 32'hABCD_ABCD);
    chk("sh_addr",  dmem.addr, 32'h200);
    @(negedge clk); nop_inputs(); dmem.ack = 1'b1;
    @(posedge clk); #1;
    chk("sh_aluo",  AluOuto, 32'h202);
    chk("sh_regwo", 32'(regesterWo), 32'h0);
    chk("sh_req_drop", 32'(dmem.req), 32'h0);
    @(negedge clk); dmem.ack = 1'b0;

    // LHU at 0x2, ack under stall, release two cycles later
    @(negedge clk);
    AluOut = 32'h2; memRead = 1'b1; funct3 = 3'b101; Rd = 5'd9; regesterW = 1'b1;
    @(posedge clk); #1;
    chk("lhu_req", 32'(dmem.req), 32'h1);
    @(negedge clk); nop_inputs();
    stall = 1'b1; dmem.ack = 1'b1; dmem.rdata = 32'hF00D_0000;
    #1 chk("lhu_ack_sreq", 32'(stall_req), 32'h1);
    @(posedge clk); #1;
    chk("lhu_req_drop", 32'(dmem.req), 32'h0);
    chk("lhu_held_aluo", AluOuto, 32'h0);
    @(negedge clk); dmem.ack = 1'b0; dmem.rdata = 32'h0;
    #1 chk("lhu_hold_sreq", 32'(stall_req), 32'h1);
    @(posedge clk); #1;
    chk("lhu_hold_aluo", AluOuto, 32'h0);
    @(negedge clk); stall = 1'b0;
    #1 chk("lhu_rel_sreq", 32'(stall_req), 32'h0);
    @(posedge clk); #1;
    chk("lhu_aluo",  AluOuto, 32'h0000_F00D);
    chk("lhu_rdo",   32'(Rdo), 32'd9);
    chk("lhu_regwo", 32'(regesterWo), 32'h1);

    // reset while BUSY
    @(negedge clk);
    AluOut = 32'h10; memRead = 1'b1; funct3 = 3'b010; Rd = 5'd4; regesterW = 1'b1;
    @(posedge clk); #1;
    chk("rb_req", 32'(dmem.req), 32'h1);
    @(negedge clk); nop_inputs(); rst = 1'b0;
    #1;
    chk("rb_req_drop", 32'(dmem.req), 32'h0);
    chk("rb_aluo",  AluOuto, 32'h0);
    chk("rb_rdo",   32'(Rdo), 32'h0);
    chk("rb_regwo", 32'(regesterWo), 32'h0);
    chk("rb_sreq",  32'(stall_req), 32'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    AluOut = 32'h77; Rd = 5'd2; regesterW = 1'b1;
    #1 chk("rb_idle_sreq", 32'(stall_req), 32'h0);
    @(posedge clk); #1;
    chk("rb_idle_aluo", AluOuto, 32'h77);
    chk("rb_idle_req",  32'(dmem.req), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
